// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM state codes, frame
// geometry and the microsecond-to-cycle conversion used to size timers.
package ps2_pkg;

   localparam int FRAME_LEN = 11;

   typedef logic [1:0] ps2_state_t;

   localparam ps2_state_t IDLE    = 2'd0;
   localparam ps2_state_t RECV    = 2'd1;
   localparam ps2_state_t INHIBIT = 2'd2;

   // 64-bit intermediate so CLK_FREQ * us cannot overflow for realistic clocks
   function automatic int us_to_cycles(input longint clk_freq, input int us);
      longint cycles;
      cycles = (clk_freq * longint'(us)) / longint'(1000000);
      return int'(cycles);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a persistence filter: the output only
// follows the synchronised input after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filtered
);

   localparam int CNT_W = $clog2(FILTER_LEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Any sample agreeing with the current level restarts the run count,
   // so short glitches never reach the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         cnt      <= '0;
         filtered <= 1'b1;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == filtered) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            filtered <= sync2;
            cnt      <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_deser.sv
// PS/2 device-to-host receiver: filters the raw lines, deserialises 11-bit
// frames, checks odd parity and stop bit, and inhibits the bus after bad frames.
module ps2_rx_deser
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ   = 28000000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 150,
   parameter int INHIBIT_US = 120
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_out,
   output logic       ps2_dat_out,
   output logic [7:0] dataout,
   output logic       dataout_valid,
   output logic       dataout_error
);

   localparam int TIMEOUT_CYC = us_to_cycles(longint'(CLK_FREQ), TIMEOUT_US);
   localparam int INHIBIT_CYC = us_to_cycles(longint'(CLK_FREQ), INHIBIT_US);
   localparam int TO_W        = $clog2(TIMEOUT_CYC) + 1;
   localparam int INH_W       = $clog2(INHIBIT_CYC) + 1;
   localparam int BIT_W       = $clog2(FRAME_LEN);

   localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [INH_W-1:0] INHIBIT_LAST = INH_W'(INHIBIT_CYC - 1);
   localparam logic [BIT_W-1:0] STOP_BIT     = BIT_W'(FRAME_LEN - 1);
   localparam logic [BIT_W-1:0] PARITY_BIT   = BIT_W'(FRAME_LEN - 2);

   logic             clk_filt;
   logic             dat_filt;
   logic             clk_prev;
   logic             armed;
   logic             fall;

   ps2_state_t       state;
   logic [BIT_W-1:0] bit_cnt;
   logic [7:0]       shift_reg;
   logic             parity_acc;
   logic [TO_W-1:0]  timeout_cnt;
   logic [INH_W-1:0] inhibit_cnt;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (ps2_clk_in),
      .filtered (clk_filt)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (ps2_dat_in),
      .filtered (dat_filt)
   );

   assign ps2_dat_out = 1'b1;

   // Our own inhibit holds the filtered clock low; the detector stays
   // disarmed until the line has been seen high again after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_prev <= 1'b1;
         armed    <= 1'b1;
      end else begin
         clk_prev <= clk_filt;
         if (state == INHIBIT) begin
            armed <= 1'b0;
         end else if (clk_filt) begin
            armed <= 1'b1;
         end
      end
   end

   assign fall = armed & clk_prev & ~clk_filt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         shift_reg     <= '0;
         parity_acc    <= 1'b0;
         timeout_cnt   <= '0;
         inhibit_cnt   <= '0;
         dataout       <= '0;
         dataout_valid <= 1'b0;
         dataout_error <= 1'b0;
         ps2_clk_out   <= 1'b1;
      end else begin
         dataout_valid <= 1'b0;
         dataout_error <= 1'b0;
         case (state)
            IDLE: begin
               if (fall) begin
                  if (!dat_filt) begin
                     state       <= RECV;
                     bit_cnt     <= BIT_W'(1);
                     parity_acc  <= 1'b0;
                     timeout_cnt <= '0;
                  end else begin
                     dataout_error <= 1'b1;
                     state         <= INHIBIT;
                     ps2_clk_out   <= 1'b0;
                     inhibit_cnt   <= '0;
                  end
               end
            end
            RECV: begin
               if (fall) begin
                  timeout_cnt <= '0;
                  if (bit_cnt == STOP_BIT) begin
                     // parity_acc already includes the parity bit: odd parity means 1
                     if (parity_acc && dat_filt) begin
                        dataout       <= shift_reg;
                        dataout_valid <= 1'b1;
                        state         <= IDLE;
                     end else begin
                        dataout_error <= 1'b1;
                        state         <= INHIBIT;
                        ps2_clk_out   <= 1'b0;
                        inhibit_cnt   <= '0;
                     end
                  end else begin
                     if (bit_cnt != PARITY_BIT) begin
                        shift_reg <= {dat_filt, shift_reg[7:1]};
                     end
                     parity_acc <= parity_acc ^ dat_filt;
                     bit_cnt    <= bit_cnt + 1'b1;
                  end
               end else if (timeout_cnt == TIMEOUT_LAST) begin
                  dataout_error <= 1'b1;
                  state         <= INHIBIT;
                  ps2_clk_out   <= 1'b0;
                  inhibit_cnt   <= '0;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            INHIBIT: begin
               if (inhibit_cnt == INHIBIT_LAST) begin
                  ps2_clk_out <= 1'b1;
                  state       <= IDLE;
               end else begin
                  inhibit_cnt <= inhibit_cnt + 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               ps2_clk_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_rx_deser.sv
// Scoreboard bench for ps2_rx_deser: a behavioural PS/2 device drives frames,
// expected strobes are queued at send time and matched as the receiver reports.
`timescale 1ns/1ps
module tb_ps2_rx_deser;

   localparam int INHIBIT_CYC = 3360;

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_out;
   logic       ps2_dat_out;
   logic [7:0] dataout;
   logic       dataout_valid;
   logic       dataout_error;

   exp_t       exp_q[$];
   exp_t       exp_item;
   logic [7:0] last_good = 8'h00;
   logic       prev_strobe = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         err_cyc = 0;
   int         low_len = 0;
   int         last_inhibit = 0;
   int         n_valid = 0;
   int         n_error = 0;
   int         t_last = 0;

   // Open-drain bus: either side can pull a line low
   assign ps2_clk_in = dev_clk & ps2_clk_out;
   assign ps2_dat_in = dev_dat & ps2_dat_out;

   ps2_rx_deser #(
      .CLK_FREQ   (28000000),
      .FILTER_LEN (8),
      .TIMEOUT_US (150),
      .INHIBIT_US (120)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ps2_clk_in    (ps2_clk_in),
      .ps2_dat_in    (ps2_dat_in),
      .ps2_clk_out   (ps2_clk_out),
      .ps2_dat_out   (ps2_dat_out),
      .dataout       (dataout),
      .dataout_valid (dataout_valid),
      .dataout_error (dataout_error)
   );

   always #18 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", tag, actual, expected, cyc);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!ps2_clk_out) begin
         low_len++;
      end else if (low_len != 0) begin
         last_inhibit = low_len;
         low_len = 0;
      end
      if (rst_n && (dataout_valid || dataout_error)) begin
         if (dataout_valid) n_valid++;
         if (dataout_error) begin
            n_error++;
            err_cyc = cyc;
         end
         check_output("strobe_exclusive", 32'(dataout_valid & dataout_error), 32'd0);
         check_output("strobe_one_cycle", 32'(prev_strobe), 32'd0);
         if (exp_q.size() == 0) begin
            check_output("unexpected_strobe", {30'd0, dataout_valid, dataout_error}, 32'd0);
         end else begin
            exp_item = exp_q.pop_front();
            check_output("strobe_kind", 32'(dataout_error), 32'(exp_item.is_err));
            check_output("dataout", 32'(dataout), 32'(exp_item.data));
         end
      end
      prev_strobe = dataout_valid | dataout_error;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b, input int half, input logic glitch);
      dev_dat = b;
      if (glitch) begin
         wait_cycles(half / 3);
         dev_clk = 1'b0;
         wait_cycles(3);
         dev_clk = 1'b1;
         wait_cycles(half - half / 3 - 3);
      end else begin
         wait_cycles(half);
      end
      dev_clk = 1'b0;
      t_last = cyc;
      wait_cycles(half);
      dev_clk = 1'b1;
   endtask

   task automatic apply_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int half, input int glitch_bit);
      logic [10:0] fr;
      logic        good;
      good = ((^d) ^ par) & stop;
      exp_q.push_back('{is_err: !good, data: (good ? d : last_good)});
      if (good) last_good = d;
      fr = {stop, par, d, 1'b0};
      for (int i = 0; i < 11; i++) drive_bit(fr[i], half, i == glitch_bit);
      dev_dat = 1'b1;
      wait_cycles(half);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 8000 && exp_q.size() != 0; i++) @(negedge clk);
      check_output({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_release(input string tag);
      for (int i = 0; i < 6000 && !ps2_clk_out; i++) @(negedge clk);
      wait_cycles(40);
      check_output({tag, "_inhibit_len"}, 32'(last_inhibit), 32'(INHIBIT_CYC));
      check_output({tag, "_released"}, 32'(ps2_clk_out), 32'd1);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0;
      wait_cycles(5);
      check_output("rst_dataout", 32'(dataout), 32'h00);
      check_output("rst_valid", 32'(dataout_valid), 32'd0);
      check_output("rst_error", 32'(dataout_error), 32'd0);
      check_output("rst_clk_out", 32'(ps2_clk_out), 32'd1);
      check_output("rst_dat_out", 32'(ps2_dat_out), 32'd1);
      rst_n = 1'b1;
      wait_cycles(20);

      // Good frame at 12.5 kHz
      apply_frame(8'h1C, 1'b0, 1'b1, 1120, -1);
      wait_drain("good_1c");
      check_output("good_1c_no_inhibit", 32'(ps2_clk_out), 32'd1);

      // Bad parity
      last_inhibit = 0;
      apply_frame(8'h1C, 1'b1, 1'b1, 150, -1);
      wait_drain("bad_par");
      wait_release("bad_par");

      // Bad stop bit with correct parity
      last_inhibit = 0;
      apply_frame(8'hF0, 1'b1, 1'b0, 150, -1);
      wait_drain("bad_stop");
      wait_release("bad_stop");

      // Start bit plus five data bits, then the device goes quiet
      last_inhibit = 0;
      exp_q.push_back('{is_err: 1'b1, data: last_good});
      drive_bit(1'b0, 150, 1'b0);
      drive_bit(1'b1, 150, 1'b0);
      drive_bit(1'b0, 150, 1'b0);
      drive_bit(1'b1, 150, 1'b0);
      drive_bit(1'b1, 150, 1'b0);
      drive_bit(1'b0, 150, 1'b0);
      dev_dat = 1'b1;
      wait_cycles(5600 - 150);
      wait_drain("timeout");
      lat = err_cyc - t_last;
      check_output("timeout_latency_ok", 32'((lat >= 4200) && (lat <= 4230)), 32'd1);
      wait_release("timeout");

      apply_frame(8'hE0, 1'b0, 1'b1, 150, -1);
      wait_drain("good_e0");

      // Short low glitches while idle and in the middle of a bit
      dev_clk = 1'b0;
      wait_cycles(3);
      dev_clk = 1'b1;
      wait_cycles(30);
      apply_frame(8'h5A, 1'b1, 1'b1, 150, 4);
      wait_drain("glitch_5a");

      // Reset in the middle of a frame
      drive_bit(1'b0, 150, 1'b0);
      drive_bit(1'b1, 150, 1'b0);
      drive_bit(1'b0, 150, 1'b0);
      drive_bit(1'b0, 150, 1'b0);
      drive_bit(1'b1, 150, 1'b0);
      wait_cycles(20);
      rst_n = 1'b0;
      wait_cycles(3);
      check_output("midrst_dataout", 32'(dataout), 32'h00);
      check_output("midrst_valid", 32'(dataout_valid), 32'd0);
      check_output("midrst_error", 32'(dataout_error), 32'd0);
      check_output("midrst_clk_out", 32'(ps2_clk_out), 32'd1);
      dev_dat = 1'b1;
      dev_clk = 1'b1;
      last_good = 8'h00;
      rst_n = 1'b1;
      wait_cycles(30);
      apply_frame(8'h29, 1'b0, 1'b1, 150, -1);
      wait_drain("after_rst_29");

      check_output("total_valid", 32'(n_valid), 32'd4);
      check_output("total_error", 32'(n_error), 32'd3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #10ms;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/ps2_rx_deser.md
# ps2_rx_deser

PS/2 device-to-host receiver: synchronises and deglitches the raw PS/2 clock and data lines, deserialises 11-bit frames, checks framing and parity, and hands each byte to the keyboard decoder as a single-cycle strobe. It sits directly upstream of the PS/2 scancode decoder and drives the open-drain clock line low to request a retransmit after any bad frame.

## Interface

Parameters:
- CLK_FREQ, 28000000, system clock frequency in Hz.
- FILTER_LEN, 8, consecutive equal samples needed to accept a line level change.
- TIMEOUT_US, 150, maximum gap between falling clock edges inside a frame.
- INHIBIT_US, 120, duration the clock line is held low after an error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ps2_clk_in  in  1  raw PS/2 clock pin level.
- ps2_dat_in  in  1  raw PS/2 data pin level.
- ps2_clk_out  out  1  open-drain clock drive; 0 pulls low, 1 releases.
- ps2_dat_out  out  1  open-drain data drive; always 1 (released).
- dataout  out  8  last received byte, LSB first on the wire.
- dataout_valid  out  1  one-cycle strobe: dataout holds a new good byte.
- dataout_error  out  1  one-cycle strobe: frame was discarded.

## Operation

- Input path: each line passes a 2-FF synchroniser, then a filter: the filtered level changes only after FILTER_LEN consecutive equal synchronised samples.
- Falling edge of filtered clock (1 then 0) samples filtered data.
- States: IDLE, RECV, INHIBIT.
- IDLE: on falling edge with data 0 (start bit) -> RECV, bit counter = 1, parity accumulator cleared, timeout counter cleared. Falling edge with data 1 -> dataout_error, go INHIBIT.
- RECV: each falling edge shifts data into shift register (right shift, LSB first) for bits 1..8; bit 9 is parity; bit 10 is stop.
  - On bit 10: if XOR of 8 data bits and parity = 1 (odd parity) and stop = 1 -> dataout loaded, dataout_valid pulsed, -> IDLE. Otherwise dataout_error pulsed, dataout unchanged, -> INHIBIT.
  - Timeout counter increments each cycle, clears on each falling edge; reaching TIMEOUT_US*CLK_FREQ/1e6 -> dataout_error, -> INHIBIT.
- INHIBIT: ps2_clk_out = 0 for INHIBIT_US*CLK_FREQ/1e6 cycles; edges ignored; then release, -> IDLE. Filtered clock will read low during inhibit; edge detector is re-armed only after release and filtered clock seen high.
- dataout_valid and dataout_error never asserted together.
- Counter widths: $clog2 of the computed cycle counts plus 1.

## Timing

- Reset values: dataout 0x00, dataout_valid 0, dataout_error 0, ps2_clk_out 1, ps2_dat_out 1, state IDLE, filters at 1.
- Latency from raw pin change to filtered change: 2 + FILTER_LEN cycles.
- dataout_valid/error assert on the cycle after the stop-bit (or failing) edge is detected; high exactly one cycle.
- dataout stable from valid strobe until next valid strobe.
- Reset asserted mid-frame: partial frame dropped, no strobe, clock released immediately.

## Structure

- Shared package ps2_pkg: state enum (IDLE, RECV, INHIBIT), frame length constant 11, helper function us_to_cycles(CLK_FREQ, us).
- One sub-module, ps2_line_filter (synchroniser + FILTER_LEN filter), instantiated twice (clock, data).

## Test plan

- Frame 0x1C, parity 0, stop 1, 12.5 kHz clock -> one dataout_valid, dataout = 0x1C, no error.
- Frame 0x1C with parity 1 -> dataout_error one cycle, dataout stays 0x1C from previous, ps2_clk_out low for INHIBIT_US worth of cycles (3360 at 28 MHz).
- Frame 0xF0, parity 1, stop 0 -> dataout_error, INHIBIT entered, no valid.
- Start bit plus 5 bits then clock idle 200 us -> dataout_error at 150 us after last edge; next full frame 0xE0 received correctly.
- 3-cycle low glitch on ps2_clk_in during IDLE and mid-frame -> no bit sampled, frame 0x5A still decoded correctly.
- rst_n pulsed after bit 4 of a frame -> all outputs at reset values, following frame 0x29 decoded correctly.
